// File: rtl/trig_cmd_readout.sv
// trig_cmd_readout: host command parser and histogram dump engine; TRIG_CMD_CHECKSUM_EN appends an XOR byte to each dump
module trig_cmd_readout #(
  parameter int SETTLE      = 3,
  parameter int TIMEOUT     = 1000000,
  parameter int RESET_PULSE = 4
) (
  input  logic         clk_adc,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  input  logic [255:0] histosout,
  output logic [7:0]   histostosend,
  output logic         resethist,
  output logic [31:0]  prescale,
  output logic [7:0]   calibticks,
  output logic         busy,
  output logic         rx_drop
);
  localparam int PW = $clog2(RESET_PULSE + 1);
  localparam logic [19:0]   TO_LAST = 20'(TIMEOUT - 1);
  localparam logic [3:0]    ST_LAST = 4'(SETTLE - 1);
  localparam logic [PW-1:0] PULSE   = PW'(RESET_PULSE);
`ifdef TRIG_CMD_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, ARG, SETTLE_S, LATCH, SEND, CKSUM} state_t;
`else
  typedef enum logic [2:0] {IDLE, ARG, SETTLE_S, LATCH, SEND} state_t;
`endif
  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d, hsel_q, hsel_d, calib_q, calib_d;
  logic [2:0]    arg_cnt_q, arg_cnt_d;
  logic [23:0]   arg_q, arg_d;
  logic [19:0]   timeout_q, timeout_d;
  logic [3:0]    settle_q, settle_d;
  logic [5:0]    byte_q, byte_d;
  logic [255:0]  shadow_q, shadow_d;
  logic [31:0]   prescale_q, prescale_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    sh_byte;
  logic          last_arg;
  assign sh_byte      = shadow_q[{byte_q[4:0], 3'b000} +: 8];
  assign last_arg     = arg_cnt_q == ((cmd_q == 8'h04) ? 3'd3 : 3'd0);
  assign tx_valid     = tx_valid_q;
  assign histostosend = hsel_q;
  assign prescale     = prescale_q;
  assign calibticks   = calib_q;
  assign resethist    = pulse_q != '0;
  assign busy         = state_q != IDLE;
  assign rx_drop      = rx_valid && !rst && state_q != IDLE && state_q != ARG;
`ifdef TRIG_CMD_CHECKSUM_EN
  logic [7:0] cksum;
  // XOR of the whole latched snapshot, sent as the trailing byte
  always_comb begin
    cksum = '0;
    for (int i = 0; i < 32; i++) cksum ^= shadow_q[8*i +: 8];
  end
  assign tx_data = tx_valid_q ? ((state_q == CKSUM) ? cksum : sh_byte) : 8'h00;
`else
  assign tx_data = tx_valid_q ? sh_byte : 8'h00;
`endif
  // next-state: command decode, argument collection, settle/latch and byte streaming
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    hsel_d     = hsel_q;
    calib_d    = calib_q;
    prescale_d = prescale_q;
    arg_cnt_d  = arg_cnt_q;
    arg_d      = arg_q;
    timeout_d  = timeout_q;
    settle_d   = settle_q;
    byte_d     = byte_q;
    shadow_d   = shadow_q;
    tx_valid_d = tx_valid_q;
    pulse_d    = resethist ? pulse_q - 1'b1 : pulse_q;
    case (state_q)
      IDLE: if (rx_valid) begin
        cmd_d     = rx_data;
        arg_cnt_d = '0;
        timeout_d = '0;
        settle_d  = '0;
        state_d   = (rx_data == 8'h01 || rx_data == 8'h04 || rx_data == 8'h05) ? ARG :
                    (rx_data == 8'h02) ? SETTLE_S : IDLE;
        pulse_d   = (rx_data == 8'h03) ? PULSE : pulse_d;
      end
      ARG: if (rx_valid) begin
        timeout_d  = '0;
        arg_d      = {rx_data, arg_q[23:8]};
        arg_cnt_d  = last_arg ? arg_cnt_q : arg_cnt_q + 1'b1;
        state_d    = last_arg ? IDLE : ARG;
        hsel_d     = (last_arg && cmd_q == 8'h01) ? rx_data : hsel_q;
        calib_d    = (last_arg && cmd_q == 8'h05) ? rx_data : calib_q;
        prescale_d = (last_arg && cmd_q == 8'h04) ? {rx_data, arg_q} : prescale_q;
      end else begin
        state_d   = (timeout_q == TO_LAST) ? IDLE : ARG;
        timeout_d = (timeout_q == TO_LAST) ? timeout_q : timeout_q + 1'b1;
      end
      SETTLE_S: begin
        state_d  = (settle_q == ST_LAST) ? LATCH : SETTLE_S;
        settle_d = (settle_q == ST_LAST) ? settle_q : settle_q + 1'b1;
      end
      LATCH: begin
        shadow_d = histosout;
        byte_d   = '0;
        state_d  = SEND;
      end
      SEND: if (!tx_valid_q) tx_valid_d = 1'b1;
      else if (tx_ready) begin
        byte_d = (byte_q == 6'd31) ? byte_q : byte_q + 1'b1;
`ifdef TRIG_CMD_CHECKSUM_EN
        state_d = (byte_q == 6'd31) ? CKSUM : SEND;
`else
        state_d    = (byte_q == 6'd31) ? IDLE : SEND;
        tx_valid_d = byte_q != 6'd31;
`endif
      end
`ifdef TRIG_CMD_CHECKSUM_EN
      CKSUM: if (tx_ready) begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge clk_adc) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      hsel_q     <= '0;
      calib_q    <= '0;
      prescale_q <= 32'hFFFF_FFFF;
      arg_cnt_q  <= '0;
      arg_q      <= '0;
      timeout_q  <= '0;
      settle_q   <= '0;
      byte_q     <= '0;
      shadow_q   <= '0;
      tx_valid_q <= 1'b0;
      pulse_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      hsel_q     <= hsel_d;
      calib_q    <= calib_d;
      prescale_q <= prescale_d;
      arg_cnt_q  <= arg_cnt_d;
      arg_q      <= arg_d;
      timeout_q  <= timeout_d;
      settle_q   <= settle_d;
      byte_q     <= byte_d;
      shadow_q   <= shadow_d;
      tx_valid_q <= tx_valid_d;
      pulse_q    <= pulse_d;
    end
  end
endmodule

// File: tb/tb_trig_cmd_readout.sv
// tb_trig_cmd_readout: randomized self-checking bench for trig_cmd_readout against a command-level model
module tb_trig_cmd_readout;
  localparam int ST = 3;
  localparam int TO = 40;
  localparam int RP = 4;
  logic         clk_adc = 0, rst = 1, rx_valid = 0, tx_ready = 1;
  logic [7:0]   rx_data = 0;
  logic [255:0] histosout = '0;
  logic [7:0]   tx_data, histostosend, calibticks;
  logic         tx_valid, resethist, busy, rx_drop;
  logic [31:0]  prescale;
  int total = 0, bad = 0;
  int acc_cnt = 0, acc_base = 0, exp_n = 0, rh_cnt = 0;
  logic [7:0]  exp_b [33];
  logic [31:0] hw [8];
  logic [31:0] exp_ps = 32'hFFFF_FFFF;
  logic [7:0]  exp_hs = 0, exp_cal = 0;
  bit slow = 0;
  trig_cmd_readout #(.SETTLE(ST), .TIMEOUT(TO), .RESET_PULSE(RP)) dut (
    .clk_adc(clk_adc), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .histosout(histosout), .histostosend(histostosend), .resethist(resethist),
    .prescale(prescale), .calibticks(calibticks), .busy(busy), .rx_drop(rx_drop)
  );
  always #5 clk_adc = ~clk_adc;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // transmitter: always ready, or ready about one cycle in three
  initial forever begin
    @(posedge clk_adc);
    #1 tx_ready = slow ? ($urandom_range(0, 2) == 0) : 1'b1;
  end
  always @(negedge clk_adc) if (resethist) rh_cnt++;
  // stream monitor: every accepted byte against the expected list, and hold stability while stalled
  logic       hold_v = 0;
  logic [7:0] hold_d = 0;
  always @(negedge clk_adc) begin
    if (tx_valid && hold_v) chk("hold", {24'd0, tx_data}, {24'd0, hold_d});
    hold_v = tx_valid && !tx_ready;
    hold_d = tx_data;
    if (tx_valid && tx_ready) begin
      chk("avail", 32'(acc_cnt - acc_base < exp_n), 1);
      if (acc_cnt - acc_base < exp_n) chk("byte", {24'd0, tx_data}, {24'd0, exp_b[acc_cnt - acc_base]});
      acc_cnt++;
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_adc);
      #1;
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1;
    tick(1);
    rx_valid = 0;
  endtask
  task automatic apply_hist();
    for (int k = 0; k < 8; k++) histosout[32*k +: 32] = hw[k];
  endtask
  task automatic chk_regs(input string tag);
    chk({tag, ".ps"}, prescale, exp_ps);
    chk({tag, ".hs"}, {24'd0, histostosend}, {24'd0, exp_hs});
    chk({tag, ".cal"}, {24'd0, calibticks}, {24'd0, exp_cal});
  endtask
  task automatic dump(input bit s, input bit perturb, input int abort_at);
    logic [7:0] x;
    int k, n;
    x = 0;
    exp_n = 0;
    for (int w = 0; w < 8; w++)
      for (int b = 0; b < 4; b++) begin
        exp_b[exp_n] = 8'((hw[w] >> (8 * b)) & 32'hFF);
        x ^= exp_b[exp_n];
        exp_n++;
      end
`ifdef TRIG_CMD_CHECKSUM_EN
    exp_b[exp_n] = x;
    exp_n++;
`endif
    acc_base = acc_cnt;
    slow = s;
    send_byte(8'h02);
    k = 0;
    do begin
      tick(1);
      k++;
    end while (!tx_valid && k < 40);
    chk("latency", k, ST + 2);
    n = 0;
    while (acc_cnt - acc_base < exp_n && n < 2000) begin
      if (perturb && n == 5) begin
        for (int w = 0; w < 8; w++) hw[w] = $urandom;
        apply_hist();
      end
      if (n == 7) begin
        rx_data = 8'h04;
        rx_valid = 1;
        #1 chk("rx_drop", rx_drop, 1);
        chk("busy_send", busy, 1);
      end
      if (abort_at >= 0 && acc_cnt - acc_base == abort_at) begin
        rst = 1;
        tick(1);
        rst = 0;
        chk("rst_txv", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_txd", {24'd0, tx_data}, 0);
        exp_n = 0;
        exp_ps = 32'hFFFF_FFFF;
        exp_hs = 0;
        exp_cal = 0;
        slow = 0;
        return;
      end
      tick(1);
      rx_valid = 0;
      n++;
    end
    chk("drained", acc_cnt - acc_base, exp_n);
    slow = 0;
    tick(3);
    chk("dump_busy", busy, 0);
    chk("dump_txv", tx_valid, 0);
    chk_regs("after_dump");
  endtask
  initial begin
    int r0, c, g;
    logic [7:0] b;
    logic [7:0] pb [4];
    tick(3);
    rst = 0;
    tick(2);
    chk_regs("reset");
    chk("reset_txv", tx_valid, 0);
    chk("reset_txd", {24'd0, tx_data}, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rh", resethist, 0);
    send_byte(8'h04); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
    chk("ps_partial", prescale, 32'hFFFF_FFFF);
    send_byte(8'h12);
    exp_ps = 32'h1234_5678;
    chk_regs("ps_write");
    send_byte(8'h04); send_byte(8'hAA);
    tick(TO - 1);
    chk("to_edge_busy", busy, 1);
    tick(1);
    chk("to_busy", busy, 0);
    chk_regs("timeout");
    send_byte(8'h04); send_byte(8'h11);
    tick(TO - 1);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    exp_ps = 32'h4433_2211;
    chk_regs("to_late");
    repeat (24) begin
      c = $urandom_range(0, 3);
      if (c == 2) begin
        send_byte(8'h04);
        for (int i = 0; i < 4; i++) begin
          pb[i] = 8'($urandom);
          tick($urandom_range(0, 5));
          send_byte(pb[i]);
        end
        exp_ps = {pb[3], pb[2], pb[1], pb[0]};
      end else if (c == 3) begin
        send_byte(8'($urandom_range(6, 255)));
        chk("junk_busy", busy, 0);
      end else begin
        b = 8'($urandom);
        send_byte(c == 0 ? 8'h01 : 8'h05);
        tick($urandom_range(0, 5));
        send_byte(b);
        if (c == 0) exp_hs = b; else exp_cal = b;
      end
      tick(1);
      chk_regs("rand");
    end
    send_byte(8'h01); send_byte(8'h05);
    exp_hs = 8'h05;
    for (int w = 0; w < 8; w++) hw[w] = 32'h0500_0000 + w;
    apply_hist();
    dump(0, 0, -1);
    for (int w = 0; w < 8; w++) hw[w] = $urandom;
    apply_hist();
    dump(1, 1, -1);
    r0 = rh_cnt;
    send_byte(8'h03);
    chk("rh_start", resethist, 1);
    tick(8);
    chk("rh_width", rh_cnt - r0, RP);
    r0 = rh_cnt;
    send_byte(8'h03);
    tick(2);
    send_byte(8'h03);
    tick(8);
    chk("rh_extend", rh_cnt - r0, 3 + RP);
    for (int w = 0; w < 8; w++) hw[w] = $urandom;
    apply_hist();
    dump(0, 0, 10);
    chk_regs("rst_mid");
    dump(0, 0, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end
endmodule
